// File: rtl/clefia_pkg.sv
// Shared CLEFIA key-schedule constants, key-length encodings and lookup helpers
// used by the constant generator and the single-step constant datapath.
package clefia_pkg;

    localparam logic [15:0] P_DEF    = 16'hb7e1;
    localparam logic [15:0] Q_DEF    = 16'h243f;
    localparam logic [15:0] RED_POLY = 16'ha831;

    localparam logic [15:0] IV_128 = 16'h428a;
    localparam logic [15:0] IV_192 = 16'h7137;
    localparam logic [15:0] IV_256 = 16'hb5c0;

    localparam logic [6:0] CON_CNT_128 = 7'd60;
    localparam logic [6:0] CON_CNT_192 = 7'd84;
    localparam logic [6:0] CON_CNT_256 = 7'd92;

    localparam logic [1:0] KL_128 = 2'b00;
    localparam logic [1:0] KL_192 = 2'b01;
    localparam logic [1:0] KL_256 = 2'b10;
    localparam logic [1:0] KL_RSV = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic [15:0] iv_for(input logic [1:0] kl);
        case (kl)
            KL_192:  return IV_192;
            KL_256:  return IV_256;
            default: return IV_128;
        endcase
    endfunction

    function automatic logic [6:0] cnt_for(input logic [1:0] kl);
        case (kl)
            KL_192:  return CON_CNT_192;
            KL_256:  return CON_CNT_256;
            default: return CON_CNT_128;
        endcase
    endfunction

endpackage

// File: rtl/clefia_con_step.sv
// One step of the CLEFIA constant recurrence: the two constants derived from T
// and T multiplied by x^-1 in GF(2^16).
module clefia_con_step
    import clefia_pkg::*;
#(
    parameter logic [15:0] P_CONST = P_DEF,
    parameter logic [15:0] Q_CONST = Q_DEF
) (
    input  logic [15:0] t_i,
    output logic [31:0] con_even_o,
    output logic [31:0] con_odd_o,
    output logic [15:0] t_next_o
);

    logic [15:0] t_inv;

    assign t_inv      = ~t_i;
    assign con_even_o = {t_i ^ P_CONST, t_inv[14:0], t_inv[15]};
    assign con_odd_o  = {t_inv ^ Q_CONST, t_i[7:0], t_i[15:8]};
    // Odd T: fold in the reduction polynomial before halving, x^15 term lands in the MSB.
    assign t_next_o   = t_i[0] ? (((t_i ^ RED_POLY) >> 1) | 16'h8000) : (t_i >> 1);

endmodule

// File: rtl/clefia_con_gen.sv
// Autonomous CLEFIA constant generator: walks the T-sequence from the key-size IV
// and streams 60/84/92 constants over valid/ready, one or two per beat.
module clefia_con_gen
    import clefia_pkg::*;
#(
    parameter int          LANES   = 1,
    parameter logic [15:0] P_CONST = P_DEF,
    parameter logic [15:0] Q_CONST = Q_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            key_len,
    output logic                  con_valid,
    input  logic                  con_ready,
    output logic [32*LANES-1:0]   con_data,
    output logic [6:0]            con_idx,
    output logic                  con_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic       ADV_EVERY = (LANES == 2);
    localparam logic [6:0] STEP      = 7'(LANES);

    state_e      state_q;
    logic [15:0] t_q;
    logic [6:0]  cnt_q;
    logic [6:0]  total_q;
    logic        phase_q;
    logic        done_q;
    logic        err_q;

    logic [31:0]         con_even_w;
    logic [31:0]         con_odd_w;
    logic [15:0]         t_next_d;
    logic [32*LANES-1:0] beat_w;
    logic                run_w;
    logic                last_w;

    clefia_con_step #(
        .P_CONST (P_CONST),
        .Q_CONST (Q_CONST)
    ) u_step (
        .t_i        (t_q),
        .con_even_o (con_even_w),
        .con_odd_o  (con_odd_w),
        .t_next_o   (t_next_d)
    );

    generate
        if (LANES == 1) begin : g_one_lane
            assign beat_w = phase_q ? con_odd_w : con_even_w;
        end else if (LANES == 2) begin : g_two_lane
            assign beat_w = {con_even_w, con_odd_w};
        end else begin : g_bad_lanes
            $error("clefia_con_gen: LANES must be 1 or 2");
        end
    endgenerate

    assign run_w  = (state_q == ST_RUN);
    assign last_w = ({1'b0, cnt_q} + {1'b0, STEP}) == {1'b0, total_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            cnt_q   <= '0;
            total_q <= '0;
            phase_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (key_len == KL_RSV) begin
                            err_q <= 1'b1;
                        end else begin
                            t_q     <= iv_for(key_len);
                            total_q <= cnt_for(key_len);
                            cnt_q   <= '0;
                            phase_q <= 1'b0;
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (con_ready) begin
                        cnt_q   <= cnt_q + STEP;
                        phase_q <= ADV_EVERY ? 1'b0 : ~phase_q;
                        // Single-lane mode emits even then odd from the same T.
                        if (ADV_EVERY || phase_q) begin
                            t_q <= t_next_d;
                        end
                        if (last_w) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign con_valid = run_w;
    assign busy      = run_w;
    assign con_data  = run_w ? beat_w : '0;
    assign con_idx   = run_w ? cnt_q : '0;
    assign con_last  = run_w & last_w;
    assign done      = done_q;
    assign err       = err_q;

endmodule
